// File: rtl/xosera_pkg.sv
// Shared definitions for the playfield blend pipeline.
//   blend_mode_t  : per-pixel combine operator selected by the active mode register
//   FADE_FULL     : master fade level that leaves pixels unchanged
//   FADE_LEVEL_W  : width of fade level / target
//   FADE_RATE_W   : width of fade rate and frame counter
//   FADE_SHIFT    : right shift applied after the fade multiply
//   fade_sat()    : clamps a requested fade target to FADE_FULL
package xosera_pkg;

    typedef enum logic [2:0] {
        BLEND_ALPHA     = 3'd0,
        BLEND_ADD_CLAMP = 3'd1,
        BLEND_SUB_CLAMP = 3'd2,
        BLEND_ADD_WRAP  = 3'd3,
        BLEND_SUB_WRAP  = 3'd4,
        BLEND_A_ONLY    = 3'd5,
        BLEND_B_ONLY    = 3'd6,
        BLEND_KEY       = 3'd7
    } blend_mode_t;

    localparam int unsigned FADE_LEVEL_W = 5;
    localparam int unsigned FADE_RATE_W  = 4;
    localparam int unsigned FADE_SHIFT   = 4;

    localparam logic [FADE_LEVEL_W-1:0] FADE_FULL = 5'd16;

    function automatic logic [FADE_LEVEL_W-1:0] fade_sat(input logic [FADE_LEVEL_W-1:0] t);
        return (t > FADE_FULL) ? FADE_FULL : t;
    endfunction

endpackage

// File: rtl/video_blend_chan.sv
// One colour channel of the blender: stage 1 derives the alpha weight and the
// alpha-scaled B value, stage 2 applies the selected blend mode with clamping.
// Two register stages; the result is valid two clocks after the inputs.
// Ports:
//   clk, reset_i : pixel clock, asynchronous active-high reset
//   color_a      : playfield A channel value (bottom layer)
//   color_b      : playfield B channel value (top layer)
//   alpha        : playfield B per-pixel alpha
//   mode         : active blend mode, consumed in stage 2
//   result       : blended channel value (registered)
module video_blend_chan
    import xosera_pkg::*;
#(
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned ALPHA_W = 3
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [COLOR_W-1:0] color_a,
    input  logic [COLOR_W-1:0] color_b,
    input  logic [ALPHA_W-1:0] alpha,
    input  blend_mode_t        mode,
    output logic [COLOR_W-1:0] result
);

    localparam int unsigned WGT_W  = ALPHA_W + 1;
    localparam int unsigned PROD_W = COLOR_W + WGT_W;

    // All-ones alpha maps to the full weight so that max alpha yields exactly B.
    localparam logic [WGT_W-1:0] WGT_FULL = {1'b1, {ALPHA_W{1'b0}}};

    // ---------------- stage 1: weight and scale ----------------
    logic [WGT_W-1:0]   weight;
    logic [PROD_W-1:0]  b_prod;
    logic [COLOR_W-1:0] b_scaled;

    always_comb begin
        weight   = (&alpha) ? WGT_FULL : {1'b0, alpha};
        b_prod   = PROD_W'(color_b) * PROD_W'(weight);
        b_scaled = b_prod[ALPHA_W +: COLOR_W];
    end

    logic [COLOR_W-1:0] a_q, b_q, bs_q;
    logic [WGT_W-1:0]   w_q;
    logic               key_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            a_q   <= '0;
            b_q   <= '0;
            bs_q  <= '0;
            w_q   <= '0;
            key_q <= 1'b0;
        end else begin
            a_q   <= color_a;
            b_q   <= color_b;
            bs_q  <= b_scaled;
            w_q   <= weight;
            key_q <= (alpha != '0);
        end
    end

    // ---------------- stage 2: mode combine and clamp ----------------
    logic [PROD_W-1:0]  mix;
    logic [COLOR_W:0]   sum;
    logic [COLOR_W:0]   diff;
    logic [COLOR_W-1:0] comb;

    always_comb begin
        // Weights sum to WGT_FULL, so the mix never overflows PROD_W.
        mix  = PROD_W'(a_q) * PROD_W'(WGT_FULL - w_q) + PROD_W'(b_q) * PROD_W'(w_q);
        sum  = {1'b0, a_q} + {1'b0, bs_q};
        // Top bit of diff is the borrow out of A - Bs.
        diff = {1'b0, a_q} - {1'b0, bs_q};
        comb = a_q;
        unique case (mode)
            BLEND_ALPHA:     comb = mix[ALPHA_W +: COLOR_W];
            BLEND_ADD_CLAMP: comb = sum[COLOR_W] ? '1 : sum[COLOR_W-1:0];
            BLEND_SUB_CLAMP: comb = diff[COLOR_W] ? '0 : diff[COLOR_W-1:0];
            BLEND_ADD_WRAP:  comb = sum[COLOR_W-1:0];
            BLEND_SUB_WRAP:  comb = diff[COLOR_W-1:0];
            BLEND_A_ONLY:    comb = a_q;
            BLEND_B_ONLY:    comb = b_q;
            BLEND_KEY:       comb = key_q ? b_q : a_q;
        endcase
    end

    logic [COLOR_W-1:0] result_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            result_q <= '0;
        end else begin
            result_q <= comb;
        end
    end

    assign result = result_q;

    // Fraction bits and the guard bit of the products are intentionally dropped.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{b_prod[ALPHA_W-1:0], b_prod[PROD_W-1],
                                mix[ALPHA_W-1:0], mix[PROD_W-1]};

endmodule

// File: rtl/video_blend_pipe.sv
// Playfield blender: combines playfield A (bottom) with playfield B (top, per-pixel
// alpha) using one of 8 blend modes, then applies a frame-stepped master fade.
// Fixed 3-clock latency for pixel data and syncs. Mode and fade changes are
// shadowed and only take effect on the rising edge of vsync.
// Optional feature macro: VIDEO_BLEND_FADE_EN (fade engine and stage-3 multiply).
// Without it the fade level is fixed at full, the fade inputs are ignored and
// fade_busy_o is held low; stage 3 is then a plain register.
// Ports:
//   clk, reset_i        : pixel clock, asynchronous active-high reset
//   vsync_i, hsync_i    : input syncs (active-high vsync)
//   dv_de_i             : display enable
//   colorA_i            : {R,G,B} playfield A
//   colorB_i            : {alpha,R,G,B} playfield B
//   mode_i, mode_wr_i   : pending blend mode and its one-cycle write strobe
//   fade_target_i       : fade target 0..16 (larger values saturate to 16)
//   fade_rate_i         : frames per fade step minus 1
//   fade_wr_i           : one-cycle strobe loading fade target and rate
//   blend_rgb_o         : blended, faded pixel (0 when delayed dv_de is low)
//   hsync_o, vsync_o    : syncs delayed to match blend_rgb_o
//   dv_de_o             : display enable delayed to match blend_rgb_o
//   fade_busy_o         : high while fade level differs from target
module video_blend_pipe
    import xosera_pkg::*;
#(
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned ALPHA_W = 3
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         vsync_i,
    input  logic                         hsync_i,
    input  logic                         dv_de_i,
    input  logic [3*COLOR_W-1:0]         colorA_i,
    input  logic [ALPHA_W+3*COLOR_W-1:0] colorB_i,
    input  logic [2:0]                   mode_i,
    input  logic                         mode_wr_i,
    input  logic [FADE_LEVEL_W-1:0]      fade_target_i,
    input  logic [FADE_RATE_W-1:0]       fade_rate_i,
    input  logic                         fade_wr_i,
    output logic [3*COLOR_W-1:0]         blend_rgb_o,
    output logic                         hsync_o,
    output logic                         vsync_o,
    output logic                         dv_de_o,
    output logic                         fade_busy_o
);

    // ---------------- frame event and mode shadowing ----------------
    logic        vsync_q;
    logic        frame_evt;
    blend_mode_t mode_pend_q, mode_act_q;

    assign frame_evt = vsync_i & ~vsync_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            vsync_q     <= 1'b0;
            mode_pend_q <= BLEND_ALPHA;
            mode_act_q  <= BLEND_ALPHA;
        end else begin
            vsync_q <= vsync_i;
            if (mode_wr_i) begin
                mode_pend_q <= blend_mode_t'(mode_i);
            end
            // A write landing on the frame event bypasses the pending register.
            if (frame_evt) begin
                mode_act_q <= mode_wr_i ? blend_mode_t'(mode_i) : mode_pend_q;
            end
        end
    end

    // ---------------- stages 1-2: per-channel blend ----------------
    logic [3*COLOR_W-1:0] comb_rgb;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        video_blend_chan #(
            .COLOR_W (COLOR_W),
            .ALPHA_W (ALPHA_W)
        ) u_chan (
            .clk     (clk),
            .reset_i (reset_i),
            .color_a (colorA_i[ch*COLOR_W +: COLOR_W]),
            .color_b (colorB_i[ch*COLOR_W +: COLOR_W]),
            .alpha   (colorB_i[3*COLOR_W +: ALPHA_W]),
            .mode    (mode_act_q),
            .result  (comb_rgb[ch*COLOR_W +: COLOR_W])
        );
    end

    // ---------------- sync delay ----------------
    logic [2:0] de_q, hs_q, vs_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            de_q <= '0;
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            de_q <= {de_q[1:0], dv_de_i};
            hs_q <= {hs_q[1:0], hsync_i};
            vs_q <= {vs_q[1:0], vsync_i};
        end
    end

    // ---------------- fade engine ----------------
    logic [3*COLOR_W-1:0] faded_rgb;

`ifdef VIDEO_BLEND_FADE_EN
    logic [FADE_LEVEL_W-1:0] level_q, level_d, target_q, target_eff;
    logic [FADE_RATE_W-1:0]  rate_q, rate_eff, cnt_q, cnt_eff, cnt_d;
    logic                    busy_q;

    always_comb begin
        // A fade write coinciding with a frame event is already in force for it.
        target_eff = target_q;
        rate_eff   = rate_q;
        cnt_eff    = cnt_q;
        if (fade_wr_i) begin
            target_eff = fade_sat(fade_target_i);
            rate_eff   = fade_rate_i;
            cnt_eff    = '0;
        end
        level_d = level_q;
        cnt_d   = cnt_eff;
        if (frame_evt) begin
            if (level_q == target_eff) begin
                cnt_d = '0;
            end else if (cnt_eff == rate_eff) begin
                cnt_d   = '0;
                level_d = (level_q < target_eff) ? level_q + FADE_LEVEL_W'(1)
                                                 : level_q - FADE_LEVEL_W'(1);
            end else begin
                cnt_d = cnt_eff + FADE_RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            level_q  <= FADE_FULL;
            target_q <= FADE_FULL;
            rate_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            level_q  <= level_d;
            target_q <= target_eff;
            rate_q   <= rate_eff;
            cnt_q    <= cnt_d;
            busy_q   <= (level_q != target_q);
        end
    end

    assign fade_busy_o = busy_q;

    localparam int unsigned FMUL_W = COLOR_W + FADE_LEVEL_W;

    for (genvar ch = 0; ch < 3; ch++) begin : g_fade
        logic [FMUL_W-1:0] prod;
        logic              unused_fade_bits;
        assign prod = FMUL_W'(comb_rgb[ch*COLOR_W +: COLOR_W]) * FMUL_W'(level_q);
        assign faded_rgb[ch*COLOR_W +: COLOR_W] = prod[FADE_SHIFT +: COLOR_W];
        // level <= 16 keeps the product below 2**(COLOR_W+4); low bits are truncated.
        assign unused_fade_bits = ^{prod[FADE_SHIFT-1:0], prod[FMUL_W-1]};
    end
`else
    logic unused_fade_inputs;
    assign unused_fade_inputs = ^{fade_target_i, fade_rate_i, fade_wr_i};
    assign fade_busy_o        = 1'b0;
    assign faded_rgb          = comb_rgb;
`endif

    // ---------------- stage 3: fade and blanking ----------------
    logic [3*COLOR_W-1:0] rgb_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= de_q[1] ? faded_rgb : '0;
        end
    end

    assign blend_rgb_o = rgb_q;
    assign hsync_o     = hs_q[2];
    assign vsync_o     = vs_q[2];
    assign dv_de_o     = de_q[2];

endmodule

// File: tb/tb_video_blend_pipe.sv
module tb_video_blend_pipe;

    localparam int CW   = 4;
    localparam int AW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic                 clk;
    logic                 reset_i;
    logic                 vsync_i, hsync_i, dv_de_i;
    logic [3*CW-1:0]      colorA_i;
    logic [AW+3*CW-1:0]   colorB_i;
    logic [2:0]           mode_i;
    logic                 mode_wr_i;
    logic [4:0]           fade_target_i;
    logic [3:0]           fade_rate_i;
    logic                 fade_wr_i;
    logic [3*CW-1:0]      blend_rgb_o;
    logic                 hsync_o, vsync_o, dv_de_o, fade_busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    video_blend_pipe #(
        .COLOR_W (CW),
        .ALPHA_W (AW)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .vsync_i       (vsync_i),
        .hsync_i       (hsync_i),
        .dv_de_i       (dv_de_i),
        .colorA_i      (colorA_i),
        .colorB_i      (colorB_i),
        .mode_i        (mode_i),
        .mode_wr_i     (mode_wr_i),
        .fade_target_i (fade_target_i),
        .fade_rate_i   (fade_rate_i),
        .fade_wr_i     (fade_wr_i),
        .blend_rgb_o   (blend_rgb_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .dv_de_o       (dv_de_o),
        .fade_busy_o   (fade_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int chan_blend(int a, int b, int al, int mode);
        int full = 1 << AW;
        int w    = (al == full - 1) ? full : al;
        int bs   = (b * w) / full;
        case (mode)
            0:       return (a * (full - w) + b * w) / full;
            1:       return (a + bs > MAXC) ? MAXC : a + bs;
            2:       return (a < bs) ? 0 : a - bs;
            3:       return (a + bs) % (MAXC + 1);
            4:       return (a - bs + MAXC + 1) % (MAXC + 1);
            5:       return a;
            6:       return b;
            default: return (al != 0) ? b : a;
        endcase
    endfunction

    function automatic int pix_blend(int a, int b, int mode);
        int al = (b >> (3 * CW)) & ((1 << AW) - 1);
        int r  = 0;
        for (int ch = 2; ch >= 0; ch--) begin
            r = (r << CW) | chan_blend((a >> (ch * CW)) & MAXC, (b >> (ch * CW)) & MAXC, al, mode);
        end
        return r;
    endfunction

    function automatic int pix_fade(int p, int level);
        int r = 0;
        for (int ch = 2; ch >= 0; ch--) begin
            r = (r << CW) | ((((p >> (ch * CW)) & MAXC) * level) / 16);
        end
        return r;
    endfunction

    typedef struct {
        int pix;
        bit de;
        bit hs;
        bit vs;
    } stage_t;

    stage_t c1, c2;
    int     m_pend, m_act, m_level, m_tgt, m_rate, m_cnt;
    bit     m_vs;
    int     e_rgb;
    bit     e_hs, e_vs, e_de, e_busy;

    // Model steps on every clock edge, then compares once outputs have settled.
    initial forever begin
        @(posedge clk);
        if (reset_i) begin
            c1 = '{0, 0, 0, 0};
            c2 = '{0, 0, 0, 0};
            m_pend = 0; m_act = 0; m_level = 16; m_tgt = 16; m_rate = 0; m_cnt = 0; m_vs = 0;
            e_rgb = 0; e_hs = 0; e_vs = 0; e_de = 0; e_busy = 0;
        end else begin
            bit fe;
            e_rgb  = c2.de ? pix_fade(c2.pix, m_level) : 0;
            e_hs   = c2.hs;
            e_vs   = c2.vs;
            e_de   = c2.de;
`ifdef VIDEO_BLEND_FADE_EN
            e_busy = (m_level != m_tgt);
`else
            e_busy = 0;
`endif
            fe   = vsync_i && !m_vs;
            m_vs = vsync_i;
            if (mode_wr_i) m_pend = int'(mode_i);
            if (fe) m_act = m_pend;
`ifdef VIDEO_BLEND_FADE_EN
            if (fade_wr_i) begin
                m_tgt  = (int'(fade_target_i) > 16) ? 16 : int'(fade_target_i);
                m_rate = int'(fade_rate_i);
                m_cnt  = 0;
            end
            if (fe) begin
                if (m_level == m_tgt) m_cnt = 0;
                else if (m_cnt == m_rate) begin
                    m_level = (m_level < m_tgt) ? m_level + 1 : m_level - 1;
                    m_cnt   = 0;
                end else m_cnt++;
            end
`endif
            c2 = c1;
            c1 = '{pix_blend(int'(colorA_i), int'(colorB_i), m_act), dv_de_i, hsync_i, vsync_i};
        end
        #1;
        check("rgb", 32'(blend_rgb_o), 32'(e_rgb));
        check("hsync_o", 32'(hsync_o), 32'(e_hs));
        check("vsync_o", 32'(vsync_o), 32'(e_vs));
        check("dv_de_o", 32'(dv_de_o), 32'(e_de));
        check("fade_busy", 32'(fade_busy_o), 32'(e_busy));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input logic [11:0] a, input logic [2:0] al, input logic [11:0] b);
        colorA_i = a;
        colorB_i = {al, b};
    endtask

    task automatic wr_mode(input logic [2:0] m);
        mode_i    = m;
        mode_wr_i = 1'b1;
        cyc(1);
        mode_wr_i = 1'b0;
    endtask

    task automatic wr_fade(input logic [4:0] t, input logic [3:0] r);
        fade_target_i = t;
        fade_rate_i   = r;
        fade_wr_i     = 1'b1;
        cyc(1);
        fade_wr_i     = 1'b0;
    endtask

    task automatic frame();
        vsync_i = 1'b1;
        cyc(2);
        vsync_i = 1'b0;
        cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; vsync_i = 0; hsync_i = 0; dv_de_i = 0;
        colorA_i = '0; colorB_i = '0; mode_i = '0; mode_wr_i = 0;
        fade_target_i = '0; fade_rate_i = '0; fade_wr_i = 0;
        cyc(2);
        reset_i = 1'b0;
        dv_de_i = 1'b1;
        cyc(4);

        // Alpha blend: exact 3-cycle latency and weight extremes.
        pix(12'h840, 3'd4, 12'h0C8);
        cyc(2); check("t1_lat_2", 32'(blend_rgb_o), 32'h000);
        cyc(1); check("t1_alpha4", 32'(blend_rgb_o), 32'h484);
        pix(12'h840, 3'd7, 12'h0C8); cyc(3); check("t1_alpha7", 32'(blend_rgb_o), 32'h0C8);
        pix(12'h840, 3'd0, 12'h0C8); cyc(3); check("t1_alpha0", 32'(blend_rgb_o), 32'h840);

        // Clamped add / subtract.
        wr_mode(3'd1); frame();
        pix(12'hF80, 3'd7, 12'h3A8); cyc(3); check("t2_add_clamp", 32'(blend_rgb_o), 32'hFF8);
        wr_mode(3'd2); frame();
        pix(12'h5A3, 3'd7, 12'h824); cyc(3); check("t2_sub_clamp", 32'(blend_rgb_o), 32'h080);

        // Mode shadowing: a mid-frame write waits for the vsync rise.
        wr_mode(3'd0); frame();
        pix(12'h840, 3'd4, 12'h0C8);
        wr_mode(3'd6); cyc(5);
        check("t3_hold", 32'(blend_rgb_o), 32'h484);
        frame();
        check("t3_switch", 32'(blend_rgb_o), 32'h0C8);
        // Write coincident with the vsync rise is applied on that edge.
        mode_i = 3'd5; mode_wr_i = 1'b1; vsync_i = 1'b1;
        cyc(1); mode_wr_i = 1'b0;
        cyc(1); vsync_i = 1'b0;
        cyc(3);
        check("t3_coincident", 32'(blend_rgb_o), 32'h840);

`ifdef VIDEO_BLEND_FADE_EN
        // Fade 16 -> 8 at one step per frame.
        pix(12'hF84, 3'd0, 12'h000); cyc(3);
        check("t4_full", 32'(blend_rgb_o), 32'hF84);
        wr_fade(5'd8, 4'd0); cyc(2);
        check("t4_busy", 32'(fade_busy_o), 32'd1);
        repeat (7) frame();
        check("t4_busy7", 32'(fade_busy_o), 32'd1);
        frame();
        check("t4_idle", 32'(fade_busy_o), 32'd0);
        check("t4_level8", 32'(blend_rgb_o), 32'h742);
        // Rate 1 towards 0: one step every second frame.
        pix(12'hFFF, 3'd0, 12'h000);
        wr_fade(5'd0, 4'd1);
        frame(); frame();
        check("t5_level7", 32'(blend_rgb_o), 32'h666);
        repeat (14) frame();
        check("t5_black", 32'(blend_rgb_o), 32'h000);
        check("t5_idle", 32'(fade_busy_o), 32'd0);
        // Reverse mid-fade: no jump in level.
        wr_fade(5'd16, 4'd0); repeat (3) frame();
        wr_fade(5'd0, 4'd0); frame();
        check("t5_reverse", 32'(blend_rgb_o), 32'h111);
        wr_fade(5'd31, 4'd0); repeat (14) frame();
        check("t5_sat16", 32'(blend_rgb_o), 32'hFFF);
        check("t5_sat_idle", 32'(fade_busy_o), 32'd0);
`endif

        // Blanking and sync delay.
        dv_de_i = 1'b0; hsync_i = 1'b0;
        pix(12'hFFF, 3'd7, 12'hFFF); cyc(3);
        hsync_i = 1'b1;
        cyc(2); check("t6_hs_lat2", 32'(hsync_o), 32'd0);
        cyc(1); check("t6_hs_lat3", 32'(hsync_o), 32'd1);
        check("t6_blank", 32'(blend_rgb_o), 32'h000);
        check("t6_de_low", 32'(dv_de_o), 32'd0);

        // Asynchronous reset mid-line.
        dv_de_i = 1'b1;
        pix(12'hF84, 3'd7, 12'h123); cyc(3);
        check("t6_pre_reset", 32'(blend_rgb_o), 32'hF84);
        reset_i = 1'b1;
        #1;
        check("t6_rst_rgb", 32'(blend_rgb_o), 32'h000);
        check("t6_rst_hs", 32'(hsync_o), 32'd0);
        check("t6_rst_de", 32'(dv_de_o), 32'd0);
        cyc(1);
        reset_i = 1'b0;
        cyc(3);
        check("t6_post_reset", 32'(blend_rgb_o), 32'h123);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            colorA_i      = 12'($urandom);
            colorB_i      = 15'($urandom);
            dv_de_i       = ($urandom_range(0, 7) != 0);
            hsync_i       = 1'($urandom_range(0, 1));
            vsync_i       = ((i % 37) < 3);
            mode_i        = 3'($urandom);
            mode_wr_i     = ($urandom_range(0, 15) == 0);
            fade_target_i = 5'($urandom);
            fade_rate_i   = 4'($urandom_range(0, 2));
            fade_wr_i     = ($urandom_range(0, 63) == 0);
            cyc(1);
        end
        mode_wr_i = 1'b0; fade_wr_i = 1'b0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
